// File: rtl/msg_text_seq.sv
// Typewriter-style message generator for the tic-tac-toe text overlay.
// Maps a character column to a registered ASCII code. Reveal and blink are paced by frame ticks.
module msg_text_seq #(
    parameter int LINE_LEN      = 16,
    parameter int REVEAL_FRAMES = 4,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] msg_sel,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic       reveal_done
);

    typedef enum logic [1:0] {REVEAL, SHOW, BLINK} state_t;

    localparam logic [7:0] REVEAL_LAST = (REVEAL_FRAMES > 0) ? 8'(REVEAL_FRAMES - 1) : 8'd0;
    localparam logic [7:0] BLINK_LAST  = (BLINK_FRAMES > 0)  ? 8'(BLINK_FRAMES - 1)  : 8'd0;
    localparam logic [8:0] LINE_LIM    = 9'(LINE_LEN);
    localparam logic [6:0] SPACE       = 7'h20;

    function automatic logic [4:0] msg_len(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd5;
            2'd1:    return 5'd13;
            2'd2:    return 5'd11;
            default: return 5'd13;
        endcase
    endfunction

    // Strings are space-padded to 13 characters; index 0 is the leftmost byte.
    function automatic logic [6:0] msg_char(input logic [1:0] m, input logic [7:0] idx);
        logic [103:0] s;
        int           i;
        case (m)
            2'd0:    s = "Start        ";
            2'd1:    s = "Choose color:";
            2'd2:    s = " BLUE WINS!  ";
            default: s = " YELLOW WINS!";
        endcase
        i = int'(idx);
        if (i >= 13) return SPACE;
        return s[8*(12-i) +: 7];
    endfunction

    state_t     state, state_nxt;
    logic [4:0] reveal_cnt, reveal_nxt;
    logic [7:0] frame_cnt, frame_nxt;
    logic       blink_ph, blink_nxt;
    logic       done_nxt;
    logic [1:0] msg_q;
    logic       restart;
    logic       winner;
    logic [4:0] len_q;
    logic       hide;

    assign restart = (msg_sel != msg_q);
    assign winner  = msg_q[1];
    assign len_q   = msg_len(msg_q);
    assign hide    = ({1'b0, char_xy} >= LINE_LIM) ||
                     ({1'b0, char_xy} >= {4'd0, reveal_cnt}) ||
                     (blink_ph && winner);

    always_comb begin
        state_nxt  = state;
        reveal_nxt = reveal_cnt;
        frame_nxt  = frame_cnt;
        blink_nxt  = blink_ph;
        done_nxt   = reveal_done;
        if (restart) begin
            // A message change wins over any frame tick in the same cycle.
            state_nxt  = REVEAL;
            reveal_nxt = 5'd0;
            frame_nxt  = 8'd0;
            blink_nxt  = 1'b0;
            done_nxt   = 1'b0;
        end else begin
            case (state)
                REVEAL: begin
                    if (reveal_cnt == len_q) begin
                        done_nxt  = 1'b1;
                        frame_nxt = 8'd0;
                        state_nxt = (winner && BLINK_FRAMES > 0) ? BLINK : SHOW;
                    end else if (REVEAL_FRAMES == 0) begin
                        reveal_nxt = len_q;
                    end else if (frame_tick) begin
                        if (frame_cnt == REVEAL_LAST) begin
                            frame_nxt  = 8'd0;
                            reveal_nxt = reveal_cnt + 5'd1;
                        end else begin
                            frame_nxt = frame_cnt + 8'd1;
                        end
                    end
                end
                BLINK: begin
                    if (frame_tick) begin
                        if (frame_cnt == BLINK_LAST) begin
                            frame_nxt = 8'd0;
                            blink_nxt = ~blink_ph;
                        end else begin
                            frame_nxt = frame_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= REVEAL;
            reveal_cnt  <= 5'd0;
            frame_cnt   <= 8'd0;
            blink_ph    <= 1'b0;
            reveal_done <= 1'b0;
            msg_q       <= 2'd0;
            char_code   <= SPACE;
        end else begin
            state       <= state_nxt;
            reveal_cnt  <= reveal_nxt;
            frame_cnt   <= frame_nxt;
            blink_ph    <= blink_nxt;
            reveal_done <= done_nxt;
            msg_q       <= msg_sel;
            // Output stage: char_xy is only ever seen through this register.
            char_code   <= hide ? SPACE : msg_char(msg_q, char_xy);
        end
    end

endmodule

// File: tb/tb_msg_text_seq.sv
// Directed bench for msg_text_seq: three parameterisations share one set of inputs.
// Instance a: instant reveal, blink 2. Instance b: reveal 4, blink 30. Instance c: line length 4.
module tb_msg_text_seq;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [1:0] msg_sel;
    logic [7:0] char_xy;
    logic [6:0] code_a, code_b, code_c;
    logic       done_a, done_b, done_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    msg_text_seq #(.LINE_LEN(16), .REVEAL_FRAMES(0), .BLINK_FRAMES(2)) u_a (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .msg_sel(msg_sel),
        .char_xy(char_xy), .char_code(code_a), .reveal_done(done_a));

    msg_text_seq #(.LINE_LEN(16), .REVEAL_FRAMES(4), .BLINK_FRAMES(30)) u_b (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .msg_sel(msg_sel),
        .char_xy(char_xy), .char_code(code_b), .reveal_done(done_b));

    msg_text_seq #(.LINE_LEN(4), .REVEAL_FRAMES(0), .BLINK_FRAMES(30)) u_c (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .msg_sel(msg_sel),
        .char_xy(char_xy), .char_code(code_c), .reveal_done(done_c));

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic look(input logic [7:0] xy);
        char_xy = xy;
        tick();
    endtask

    logic [6:0] start_exp [16];

    initial begin
        start_exp = '{7'h53, 7'h74, 7'h61, 7'h72, 7'h74, 7'h20, 7'h20, 7'h20,
                      7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20};
        rst_n = 1'b0; frame_tick = 1'b0; msg_sel = 2'd0; char_xy = 8'd0;
        tick(); tick();
        check("rst_code_a", code_a, 7'h20);
        check("rst_done_a", 7'(done_a), 7'd0);
        check("rst_done_b", 7'(done_b), 7'd0);

        // Start message, instant reveal
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            look(8'(i));
            check($sformatf("start_sweep_%0d", i), code_a, start_exp[i]);
        end
        check("start_done_a", 7'(done_a), 7'd1);
        check("start_hidden_b", code_b, 7'h20);
        check("start_done_b", 7'(done_b), 7'd0);
        look(8'd3);  check("line4_in_c", code_c, 7'h72);
        look(8'd4);  check("line4_out_c", code_c, 7'h20);

        // Choose color, paced reveal
        msg_sel = 2'd1;
        tick();
        pulses(20);
        look(8'd4);  check("choose_x4_b", code_b, 7'h73);
        look(8'd5);  check("choose_x5_b", code_b, 7'h20);
        check("choose_part_done_b", 7'(done_b), 7'd0);
        pulses(32);
        check("choose_done_b", 7'(done_b), 7'd1);
        look(8'd12); check("choose_x12_b", code_b, 7'h3A);
        check("choose_x12_a", code_a, 7'h3A);
        look(8'hFF); check("choose_xff_b", code_b, 7'h20);
        look(8'd3);  check("choose_x3_c", code_c, 7'h6F);
        for (int i = 4; i <= 12; i++) begin
            look(8'(i));
            check($sformatf("choose_c_x%0d", i), code_c, 7'h20);
        end

        // Blue wins, blink every 2 ticks
        msg_sel = 2'd2;
        tick(); tick(); tick();
        look(8'd1);  check("blue_vis0", code_a, 7'h42);
        check("blue_done", 7'(done_a), 7'd1);
        pulses(1);   check("blue_vis1", code_a, 7'h42);
        pulses(1);   check("blue_off2", code_a, 7'h20);
        pulses(1);   check("blue_off3", code_a, 7'h20);
        pulses(1);   check("blue_on4", code_a, 7'h42);
        look(8'd0);  check("blue_x0", code_a, 7'h20);

        // Restart with a simultaneous tick: the tick is dropped
        msg_sel = 2'd3;
        tick();
        pulses(6);
        char_xy = 8'd0;
        msg_sel = 2'd0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        check("restart_done_b", 7'(done_b), 7'd0);
        check("restart_x0_b", code_b, 7'h20);
        pulses(3);   check("restart_3tick_b", code_b, 7'h20);
        pulses(1);   check("restart_4tick_b", code_b, 7'h53);

        // Reset while blinking in the off phase
        msg_sel = 2'd3;
        char_xy = 8'd1;
        tick(); tick(); tick();
        pulses(2);
        check("yellow_off_a", code_a, 7'h20);
        check("yellow_done_a", 7'(done_a), 7'd1);
        rst_n = 1'b0;
        tick();
        check("midblink_rst_code_a", code_a, 7'h20);
        check("midblink_rst_done_a", 7'(done_a), 7'd0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        check("post_rst_a", code_a, 7'h59);
        check("post_rst_hidden_b", code_b, 7'h20);
        pulses(4);   check("post_rst_4_b", code_b, 7'h20);
        pulses(4);   check("post_rst_8_b", code_b, 7'h59);
        look(8'd2);  check("post_rst_x2_b", code_b, 7'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
